// File: rtl/aer_rx_handshake.sv
// aer_rx_handshake: receive side of a 4-phase AER REQ/ACK link. Synchronises
// REQ, stamps each event with a prescaled free-running timestamp and pushes
// one {timestamp, address} word into the input FIFO. ACK is withheld while
// the FIFO is full, which is how backpressure reaches the off-chip sender.
module aer_rx_handshake #(
    parameter int ADDR_W   = 16,
    parameter int TS_W     = 24 - ADDR_W,   // word is exactly 24 bits wide
    parameter int PRESCALE = 100            // clk cycles per timestamp tick
) (
    input  logic              clk,
    input  logic              rst,          // async, active low
    input  logic              aer_req,
    input  logic [ADDR_W-1:0] aer_addr,
    output logic              aer_ack,
    input  logic              fifo_full,
    output logic              fifo_wr_en,
    output logic [23:0]       fifo_din,
    output logic              stall
);

    typedef enum logic [1:0] {IDLE, WRITE, ACK_HI} state_t;

    localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

    state_t            state, state_nxt;
    logic              req_meta, req_s;
    logic [15:0]       pre_cnt;
    logic [TS_W-1:0]   ts;
    logic              ack_nxt, wr_en_nxt, stall_nxt;
    logic [23:0]       din_nxt;

    // Two-flop synchroniser for the asynchronous request line. The address
    // is bundled data and is only looked at once req_s is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_meta <= 1'b0;
            req_s    <= 1'b0;
        end else begin
            req_meta <= aer_req;
            req_s    <= req_meta;
        end
    end

    // Free-running prescaler and timestamp, independent of the handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_cnt <= '0;
            ts      <= '0;
        end else if (pre_cnt == PRE_MAX) begin
            pre_cnt <= '0;
            ts      <= ts + TS_W'(1);
        end else begin
            pre_cnt <= pre_cnt + 16'd1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic: one event per full 4-phase cycle; ACK_HI waits for
    // req_s to drop so a still-high request is never captured twice.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_s)      state_nxt = WRITE;
            WRITE:   if (!fifo_full) state_nxt = ACK_HI;
            ACK_HI:  if (!req_s)     state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // Output decode: next values of the registered outputs.
    always_comb begin
        wr_en_nxt = 1'b0;
        stall_nxt = 1'b0;
        ack_nxt   = aer_ack;
        din_nxt   = fifo_din;
        case (state)
            IDLE: begin
                // timestamp is the value before this edge
                if (req_s) din_nxt = {ts, aer_addr};
            end
            WRITE: begin
                if (fifo_full) begin
                    stall_nxt = 1'b1;
                end else begin
                    wr_en_nxt = 1'b1;
                    ack_nxt   = 1'b1;
                end
            end
            ACK_HI: begin
                if (!req_s) ack_nxt = 1'b0;
            end
            default: ;
        endcase
    end

    // Registered outputs keep ACK and the FIFO strobe glitch-free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aer_ack    <= 1'b0;
            fifo_wr_en <= 1'b0;
            fifo_din   <= '0;
            stall      <= 1'b0;
        end else begin
            aer_ack    <= ack_nxt;
            fifo_wr_en <= wr_en_nxt;
            fifo_din   <= din_nxt;
            stall      <= stall_nxt;
        end
    end

endmodule

// File: tb/tb_aer_rx_handshake.sv
// Directed bench for aer_rx_handshake with PRESCALE=4. Inputs are driven
// and outputs sampled on the falling clock edge.
module tb_aer_rx_handshake;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        aer_req = 1'b0;
    logic [15:0] aer_addr = '0;
    logic        aer_ack;
    logic        fifo_full = 1'b0;
    logic        fifo_wr_en;
    logic [23:0] fifo_din;
    logic        stall;

    int checks = 0;
    int errors = 0;
    int cyc;
    int wr_cnt = 0;
    logic [23:0] wr_q[$];

    aer_rx_handshake #(.ADDR_W(16), .TS_W(8), .PRESCALE(4)) dut (
        .clk(clk), .rst(rst), .aer_req(aer_req), .aer_addr(aer_addr),
        .aer_ack(aer_ack), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
        .fifo_din(fifo_din), .stall(stall)
    );

    always #5 clk = ~clk;

    // edges since reset release
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    // record every write strobe
    always @(negedge clk) begin
        if (fifo_wr_en) begin
            wr_cnt <= wr_cnt + 1;
            wr_q.push_back(fifo_din);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // raise req now; return edges until wr_en seen (0 on timeout)
    task automatic raise_wait_wr(input logic [15:0] a, output int lat);
        int n = 0;
        aer_addr = a;
        aer_req  = 1'b1;
        lat = 0;
        while (lat == 0 && n < 200) begin
            @(negedge clk);
            n++;
            if (fifo_wr_en) lat = n;
        end
        if (lat == 0) chk("wr_timeout", 0, 1);
    endtask

    // drop req now; return edges until ack falls
    task automatic drop_wait_ack(output int n);
        aer_req = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (aer_ack && n < 50);
        if (aer_ack) chk("ack_timeout", 0, 1);
    endtask

    initial begin
        int lat, n, base, bad;

        // reset state
        rst = 1'b0;
        #12;
        chk("rst_ack", aer_ack, 0);
        chk("rst_wr", fifo_wr_en, 0);
        chk("rst_din", fifo_din, 0);
        chk("rst_stall", stall, 0);
        @(negedge clk);
        rst = 1'b1;

        // single event at cycle 0, timestamp 0
        raise_wait_wr(16'hA5C3, lat);
        chk("single_lat", lat, 4);
        chk("single_din", fifo_din, 24'h00A5C3);
        chk("single_ack", aer_ack, 1);
        drop_wait_ack(n);
        chk("ack_fall_lat", n, 3);
        chk("single_cnt", wr_cnt, 1);

        // timestamp at cycle 40: (40+2)/4 = 10
        while (cyc != 40) @(negedge clk);
        raise_wait_wr(16'h1234, lat);
        chk("ts_40", fifo_din[23:16], 8'h0A);
        drop_wait_ack(n);
        // cycle 1100: 1102/4 = 275 -> 0x13
        while (cyc != 1100) @(negedge clk);
        raise_wait_wr(16'h4321, lat);
        chk("ts_1100", fifo_din[23:16], 8'h13);
        chk("ts_1100_addr", fifo_din[15:0], 16'h4321);
        drop_wait_ack(n);

        // backpressure
        base = wr_cnt;
        fifo_full = 1'b1;
        aer_addr = 16'h0001;
        aer_req = 1'b1;
        repeat (20) @(negedge clk);
        chk("bp_stall", stall, 1);
        chk("bp_ack", aer_ack, 0);
        chk("bp_nowr", wr_cnt - base, 0);
        fifo_full = 1'b0;
        @(negedge clk);
        chk("bp_wr", fifo_wr_en, 1);
        chk("bp_addr", fifo_din[15:0], 16'h0001);
        chk("bp_ack_hi", aer_ack, 1);
        chk("bp_stall_clr", stall, 0);
        @(negedge clk);
        chk("bp_wr_pulse", fifo_wr_en, 0);
        drop_wait_ack(n);
        chk("bp_cnt", wr_cnt - base, 1);

        // back-to-back 64 events
        do_reset();
        base = wr_cnt;
        wr_q.delete();
        for (int i = 0; i < 64; i++) begin
            raise_wait_wr(16'(i), lat);
            drop_wait_ack(n);
        end
        repeat (5) @(negedge clk);
        chk("b2b_cnt", wr_cnt - base, 64);
        bad = 0;
        for (int i = 0; i < 64; i++)
            if (i >= wr_q.size() || wr_q[i][15:0] != 16'(i)) bad++;
        chk("b2b_order", bad, 0);

        // reset while stalled in WRITE
        fifo_full = 1'b1;
        aer_addr = 16'hBEEF;
        aer_req = 1'b1;
        repeat (6) @(negedge clk);
        chk("mid_stall_pre", stall, 1);
        #2 rst = 1'b0;
        #1;
        chk("mid_ack", aer_ack, 0);
        chk("mid_wr", fifo_wr_en, 0);
        chk("mid_stall", stall, 0);
        chk("mid_din", fifo_din, 0);
        fifo_full = 1'b0;
        @(negedge clk);
        base = wr_cnt;
        rst = 1'b1;
        lat = 0;
        n = 0;
        while (lat == 0 && n < 50) begin
            @(negedge clk);
            n++;
            if (fifo_wr_en) lat = n;
        end
        chk("mid_relat", lat, 4);
        chk("mid_addr", fifo_din[15:0], 16'hBEEF);
        drop_wait_ack(n);
        repeat (5) @(negedge clk);
        chk("mid_cnt", wr_cnt - base, 1);

        // short request pulse (7 ns) spanning one rising edge
        base = wr_cnt;
        aer_addr = 16'h00C7;
        aer_req = 1'b1;
        #7 aer_req = 1'b0;
        lat = 0;
        n = 0;
        while (lat == 0 && n < 50) begin
            @(negedge clk);
            n++;
            if (fifo_wr_en) lat = n;
        end
        chk("glitch_seen", lat != 0, 1);
        chk("glitch_addr", fifo_din[15:0], 16'h00C7);
        repeat (6) @(negedge clk);
        chk("glitch_ack", aer_ack, 0);
        chk("glitch_cnt", wr_cnt - base, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
